csr_file: RTL and testbench
===========================

Name: csr_file

Overview:
Machine-mode CSR register file for the single-cycle RV32 core. It is the responder for the csr_rd/csr_wr/is_mret strobes that the controller raises.
- Serves CSRRW/CSRRS/CSRRC reads and writes.
- Counts cycles.
- Synchronises the timer interrupt and performs trap entry and MRET return.
- Gives the fetch stage a PC redirect target.

Parameters:
XLEN, 32, data width of every CSR.
MTVEC_RESET, 32'h0000_0000, reset value of mtvec.
SYNC_STAGES, 2, flop depth of the timer_irq synchroniser (must be 2 or more).

Ports:
clk  in  1  core clock
rst  in  1  asynchronous, active-high reset
csr_rd  in  1  read strobe from controller
csr_wr  in  1  write strobe from controller
is_mret  in  1  MRET strobe from controller
csr_addr  in  12  CSR address, inst[31:20]
csr_op  in  3  func3 of the CSR instruction
csr_wdata  in  XLEN  rs1 value, or zero-extended zimm (already muxed by the datapath)
pc  in  XLEN  PC of the current instruction
timer_irq  in  1  asynchronous machine-timer interrupt request
csr_rdata  out  XLEN  old value of the addressed CSR
trap_taken  out  1  interrupt is taken this cycle
redirect  out  1  trap_taken OR is_mret
redirect_pc  out  XLEN  next-PC override

Behaviour:
- Registers and addresses:
  - mstatus 0x300: only MIE[3] and MPIE[7] are stored; all other bits read 0.
  - mie 0x304: only MTIE[7] is stored.
  - mtvec 0x305: bits [1:0] hardwired to 0 (direct mode only).
  - mepc 0x341: bits [1:0] hardwired to 0.
  - mcause 0x342: full 32 bits.
  - mip 0x344: read-only; MTIP[7] is the synchroniser output.
  - mcycle 0xB00 and mcycleh 0xB80: low and high words of a 64-bit counter.
- Reset (async): every register is 0 except mtvec = MTVEC_RESET. Synchroniser flops are cleared.
  - After reset: trap_taken = 0, redirect = 0, csr_rdata = 0 (csr_rd is low).
  - Asserting rst mid-cycle discards any pending write or trap.
- Read (combinational, 0 latency):
  - csr_rdata is the pre-write value of csr_addr when csr_rd = 1, else 0.
  - Unimplemented addresses read 0.
- Write (takes effect on posedge clk when csr_wr = 1 and trap_taken = 0):
  - new value: csr_op[1:0] = 01 gives wdata; 10 gives old | wdata; 11 gives old & ~wdata; 00 means no write.
  - csr_op[2] is ignored by this block.
  - Read-only and hardwired bits are masked after the operation.
  - Writes to unimplemented addresses and to mip are silently dropped.
- mcycle:
  - Increments by 1 every cycle; a carry out of mcycle increments mcycleh, and 0xFFFF_FFFF_FFFF_FFFF wraps to 0.
  - If either half is written in a cycle, the written half takes the written value and the other half holds; there is no increment that cycle.
- Interrupt:
  - MTIP = timer_irq delayed through SYNC_STAGES flops.
  - trap_taken = MIE & MTIE & MTIP (combinational on register state).
- Trap entry (posedge clk when trap_taken = 1):
  - mepc <= pc & ~3; mcause <= 32'h8000_0007; MPIE <= MIE; MIE <= 0.
  - The current instruction is not retired. The datapath must gate rf_en and mem_write with ~trap_taken.
  - csr_wr and is_mret in the same cycle are discarded, so trap has priority.
- MRET (posedge clk when is_mret = 1 and trap_taken = 0): MIE <= MPIE; MPIE <= 1.
- Redirect:
  - redirect_pc = mtvec when trap_taken = 1; otherwise mepc when is_mret = 1; otherwise 0.
  - redirect = trap_taken | is_mret.
- Interrupt re-entry: a level-held timer_irq re-traps only after software sets MIE (e.g. via MRET restoring MPIE = 1).

Decomposition:
- Package csr_pkg:
  - CSR address localparams: CSR_MSTATUS, CSR_MIE, CSR_MTVEC, CSR_MEPC, CSR_MCAUSE, CSR_MIP, CSR_MCYCLE, CSR_MCYCLEH.
  - Bit indices MSTATUS_MIE = 3, MSTATUS_MPIE = 7, MIX_MT = 7.
  - MCAUSE_MTI = 32'h8000_0007.
  - csr_op_e enum: CSR_NOP, CSR_RW, CSR_RS, CSR_RC.
- Sub-module: irq_sync, a SYNC_STAGES-deep flop chain with async reset, instantiated for timer_irq.

Test Plan:
1. Reset, then read 0x305 with MTVEC_RESET = 0x100 -> csr_rdata = 0x100. Read 0x300 -> 0. mcycle reads 0, then increments by 1 each cycle.
2. CSRRW 0x305 with wdata 0x0000_0203 -> same-cycle rdata = old value; next read = 0x0000_0200. CSRRS 0x300 wdata 0xFFFF_FFFF -> reads 0x88. CSRRC 0x300 wdata 0x8 -> reads 0x80.
3. Set MIE = 1 and MTIE = 1, raise timer_irq -> trap_taken goes high exactly SYNC_STAGES edges later.
   - In that cycle: redirect_pc = mtvec.
   - Next cycle: mepc = pc, mcause = 0x8000_0007, mstatus = 0x80.
4. In the trap cycle, also drive csr_wr to 0x341 and is_mret -> both are ignored: mepc holds the trapped pc and MIE = 0.
5. With timer_irq low, is_mret and mstatus = 0x80 -> redirect = 1, redirect_pc = mepc; next cycle mstatus = 0x88.
6. Write mcycle = 0xFFFF_FFFE and mcycleh = 0 -> two cycles later mcycle = 0 and mcycleh = 1. A write in the same cycle as a wrap takes the written value.
   - Asserting rst mid-sequence -> all registers return to their reset values immediately, without waiting for clk.

Source files
------------

// File: rtl/csr_pkg.sv
// csr_pkg: CSR addresses, bit positions and op encoding shared by the CSR file
package csr_pkg;
    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MIE     = 12'h304;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;
    localparam logic [11:0] CSR_MIP     = 12'h344;
    localparam logic [11:0] CSR_MCYCLE  = 12'hB00;
    localparam logic [11:0] CSR_MCYCLEH = 12'hB80;
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;
    localparam int MIX_MT       = 7;
    localparam logic [31:0] MCAUSE_MTI = 32'h8000_0007;
    typedef enum logic [1:0] {CSR_NOP, CSR_RW, CSR_RS, CSR_RC} csr_op_e;
endpackage

// File: rtl/csr_file_irq_sync.sv
// irq_sync: multi-flop synchroniser for an asynchronous level input
module irq_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] sync_q, sync_d;
    always_comb sync_d = {sync_q[STAGES-2:0], d};
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= sync_d;
    end
    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSRs, cycle counter, timer trap entry and MRET redirect
module csr_file
    import csr_pkg::*;
#(
    parameter int               XLEN        = 32,
    parameter logic [XLEN-1:0]  MTVEC_RESET = '0,
    parameter int               SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            csr_rd,
    input  logic            csr_wr,
    input  logic            is_mret,
    input  logic [11:0]     csr_addr,
    input  logic [2:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    input  logic [XLEN-1:0] pc,
    input  logic            timer_irq,
    output logic [XLEN-1:0] csr_rdata,
    output logic            trap_taken,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc
);
    logic              mie_q, mie_d, mpie_q, mpie_d, mtie_q, mtie_d;
    logic [XLEN-1:0]   mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [2*XLEN-1:0] mcycle_q, mcycle_d;
    logic              mtip, wr_en, unused_op;
    logic [XLEN-1:0]   csr_old, wr_val, mstatus_v, mie_v, mip_v;
    csr_op_e           op;

    irq_sync #(.STAGES(SYNC_STAGES)) u_timer_sync (
        .clk (clk),
        .rst (rst),
        .d   (timer_irq),
        .q   (mtip)
    );

    assign op        = csr_op_e'(csr_op[1:0]);
    assign unused_op = csr_op[2];

    always_comb begin
        mstatus_v               = '0;
        mstatus_v[MSTATUS_MIE]  = mie_q;
        mstatus_v[MSTATUS_MPIE] = mpie_q;
        mie_v                   = '0;
        mie_v[MIX_MT]           = mtie_q;
        mip_v                   = '0;
        mip_v[MIX_MT]           = mtip;
        case (csr_addr)
            CSR_MSTATUS: csr_old = mstatus_v;
            CSR_MIE:     csr_old = mie_v;
            CSR_MTVEC:   csr_old = mtvec_q;
            CSR_MEPC:    csr_old = mepc_q;
            CSR_MCAUSE:  csr_old = mcause_q;
            CSR_MIP:     csr_old = mip_v;
            CSR_MCYCLE:  csr_old = mcycle_q[XLEN-1:0];
            CSR_MCYCLEH: csr_old = mcycle_q[2*XLEN-1:XLEN];
            default:     csr_old = '0;
        endcase
    end

    assign csr_rdata   = csr_rd ? csr_old : '0;
    assign trap_taken  = mie_q & mtie_q & mtip;
    assign redirect    = trap_taken | is_mret;
    assign redirect_pc = trap_taken ? mtvec_q : is_mret ? mepc_q : '0;
    assign wr_en       = csr_wr & ~trap_taken & (op != CSR_NOP);
    assign wr_val      = op == CSR_RW ? csr_wdata :
                         op == CSR_RS ? csr_old | csr_wdata : csr_old & ~csr_wdata;

    // trap wins over any write or MRET issued in the same cycle
    always_comb begin
        mie_d    = mie_q;
        mpie_d   = mpie_q;
        mtie_d   = mtie_q;
        mtvec_d  = mtvec_q;
        mepc_d   = mepc_q;
        mcause_d = mcause_q;
        mcycle_d = mcycle_q + 1'b1;
        if (trap_taken) begin
            mepc_d   = {pc[XLEN-1:2], 2'b00};
            mcause_d = XLEN'(MCAUSE_MTI);
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end else begin
            if (is_mret) begin
                mie_d  = mpie_q;
                mpie_d = 1'b1;
            end
            if (wr_en) begin
                case (csr_addr)
                    CSR_MSTATUS: begin
                        mie_d  = wr_val[MSTATUS_MIE];
                        mpie_d = wr_val[MSTATUS_MPIE];
                    end
                    CSR_MIE:     mtie_d   = wr_val[MIX_MT];
                    CSR_MTVEC:   mtvec_d  = {wr_val[XLEN-1:2], 2'b00};
                    CSR_MEPC:    mepc_d   = {wr_val[XLEN-1:2], 2'b00};
                    CSR_MCAUSE:  mcause_d = wr_val;
                    CSR_MCYCLE:  mcycle_d = {mcycle_q[2*XLEN-1:XLEN], wr_val};
                    CSR_MCYCLEH: mcycle_d = {wr_val, mcycle_q[XLEN-1:0]};
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mie_q    <= 1'b0;
            mpie_q   <= 1'b0;
            mtie_q   <= 1'b0;
            mtvec_q  <= {MTVEC_RESET[XLEN-1:2], 2'b00};
            mepc_q   <= '0;
            mcause_q <= '0;
            mcycle_q <= '0;
        end else begin
            mie_q    <= mie_d;
            mpie_q   <= mpie_d;
            mtie_q   <= mtie_d;
            mtvec_q  <= mtvec_d;
            mepc_q   <= mepc_d;
            mcause_q <= mcause_d;
            mcycle_q <= mcycle_d;
        end
    end
endmodule

// File: tb/tb_csr_file.sv
// tb_csr_file: directed vectors with hand-computed expectations for csr_file
module tb_csr_file;
    logic        clk = 1'b0, rst = 1'b1;
    logic        csr_rd = 1'b0, csr_wr = 1'b0, is_mret = 1'b0, timer_irq = 1'b0;
    logic [11:0] csr_addr = '0;
    logic [2:0]  csr_op = '0;
    logic [31:0] csr_wdata = '0, pc = '0;
    logic [31:0] csr_rdata, redirect_pc;
    logic        trap_taken, redirect;
    int          n_vec = 0, n_miss = 0;

    csr_file #(.XLEN(32), .MTVEC_RESET(32'h100), .SYNC_STAGES(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .csr_rd      (csr_rd),
        .csr_wr      (csr_wr),
        .is_mret     (is_mret),
        .csr_addr    (csr_addr),
        .csr_op      (csr_op),
        .csr_wdata   (csr_wdata),
        .pc          (pc),
        .timer_irq   (timer_irq),
        .csr_rdata   (csr_rdata),
        .trap_taken  (trap_taken),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [11:0] a, input logic [31:0] exp);
        csr_rd = 1'b1;
        csr_addr = a;
        #1;
        chk(tag, csr_rdata, exp);
        csr_rd = 1'b0;
    endtask

    task automatic wr(input string tag, input logic [11:0] a, input logic [2:0] o,
                      input logic [31:0] d, input bit chk_old, input logic [31:0] old);
        csr_rd = 1'b1;
        csr_wr = 1'b1;
        csr_addr = a;
        csr_op = o;
        csr_wdata = d;
        #1;
        if (chk_old) chk(tag, csr_rdata, old);
        tick();
        csr_rd = 1'b0;
        csr_wr = 1'b0;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_trap", 32'(trap_taken), 0);
        chk("rst_redir", 32'(redirect), 0);
        chk("rst_rdata_idle", csr_rdata, 0);
        rd("rst_mtvec", 12'h305, 32'h100);
        rd("rst_mstatus", 12'h300, 0);
        rd("rst_mcycle", 12'hB00, 0);
        tick();
        rd("mcycle_1", 12'hB00, 1);
        tick();
        rd("mcycle_2", 12'hB00, 2);

        wr("rw_mtvec_old", 12'h305, 3'b001, 32'h0000_0203, 1, 32'h100);
        rd("mtvec_mask", 12'h305, 32'h200);
        wr("rs_mstatus_old", 12'h300, 3'b110, 32'hFFFF_FFFF, 1, 0);
        rd("mstatus_rs", 12'h300, 32'h88);
        wr("rc_mstatus_old", 12'h300, 3'b111, 32'h8, 1, 32'h88);
        rd("mstatus_rc", 12'h300, 32'h80);
        wr("mip_wr", 12'h344, 3'b001, 32'hFFFF_FFFF, 0, 0);
        rd("mip_ro", 12'h344, 0);
        rd("unimpl", 12'h340, 0);
        wr("nop_mcause", 12'h342, 3'b000, 32'h1234, 0, 0);
        rd("mcause_nop", 12'h342, 0);
        wr("mcause_wr", 12'h342, 3'b001, 32'hDEAD_BEEF, 0, 0);
        rd("mcause_full", 12'h342, 32'hDEAD_BEEF);
        wr("mepc_wr", 12'h341, 3'b101, 32'h0000_1237, 0, 0);
        rd("mepc_mask", 12'h341, 32'h1234);
        wr("mie_wr", 12'h304, 3'b001, 32'hFFFF_FFFF, 0, 0);
        rd("mie_mtie", 12'h304, 32'h80);
        wr("mie_set", 12'h300, 3'b010, 32'h8, 1, 32'h80);

        pc = 32'h0000_4006;
        timer_irq = 1'b1;
        #1 chk("irq_e0", 32'(trap_taken), 0);
        tick();
        chk("irq_e1", 32'(trap_taken), 0);
        tick();
        chk("irq_e2_trap", 32'(trap_taken), 1);
        csr_wr = 1'b1;
        csr_addr = 12'h341;
        csr_op = 3'b001;
        csr_wdata = 32'h5555_5555;
        is_mret = 1'b1;
        #1;
        chk("trap_redir", 32'(redirect), 1);
        chk("trap_rpc", redirect_pc, 32'h200);
        tick();
        csr_wr = 1'b0;
        is_mret = 1'b0;
        chk("post_trap_off", 32'(trap_taken), 0);
        rd("trap_mepc", 12'h341, 32'h4004);
        rd("trap_mcause", 12'h342, 32'h8000_0007);
        rd("trap_mstatus", 12'h300, 32'h80);
        rd("mip_high", 12'h344, 32'h80);

        timer_irq = 1'b0;
        tick();
        tick();
        rd("mip_low", 12'h344, 0);
        is_mret = 1'b1;
        #1;
        chk("mret_redir", 32'(redirect), 1);
        chk("mret_rpc", redirect_pc, 32'h4004);
        tick();
        is_mret = 1'b0;
        rd("mret_mstatus", 12'h300, 32'h88);
        chk("mret_no_trap", 32'(trap_taken), 0);

        wr("mcyc_lo", 12'hB00, 3'b001, 32'hFFFF_FFFE, 0, 0);
        wr("mcyc_hi", 12'hB80, 3'b001, 32'h0, 0, 0);
        rd("mcyc_hold", 12'hB00, 32'hFFFF_FFFE);
        tick();
        rd("mcyc_ff", 12'hB00, 32'hFFFF_FFFF);
        tick();
        rd("mcyc_carry_lo", 12'hB00, 0);
        rd("mcyc_carry_hi", 12'hB80, 1);
        wr("mcyc_lo_max", 12'hB00, 3'b001, 32'hFFFF_FFFF, 0, 0);
        wr("mcyc_hi_max", 12'hB80, 3'b001, 32'hFFFF_FFFF, 0, 0);
        wr("mcyc_wrap_wr", 12'hB00, 3'b001, 32'h5, 0, 0);
        rd("wrap_wr_lo", 12'hB00, 5);
        rd("wrap_wr_hi", 12'hB80, 32'hFFFF_FFFF);
        wr("mcyc_lo_max2", 12'hB00, 3'b001, 32'hFFFF_FFFF, 0, 0);
        tick();
        rd("wrap64_lo", 12'hB00, 0);
        rd("wrap64_hi", 12'hB80, 0);

        #2;
        csr_wr = 1'b1;
        csr_addr = 12'h305;
        csr_op = 3'b001;
        csr_wdata = 32'hABC0;
        rst = 1'b1;
        rd("arst_mtvec", 12'h305, 32'h100);
        rd("arst_mstatus", 12'h300, 0);
        rd("arst_mepc", 12'h341, 0);
        rd("arst_mcause", 12'h342, 0);
        tick();
        rst = 1'b0;
        csr_wr = 1'b0;
        rd("arst_drop_wr", 12'h305, 32'h100);
        rd("arst_mcycle", 12'hB00, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
